// File: rtl/skipjack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : skipjack_pkg
//  Description : Shared types, round constants and the Rule A / Rule B word
//                mixing step used by the Skipjack round controllers.
//  Revision    : 1.0 - initial release
// ============================================================================
package skipjack_pkg;

  localparam int NUM_ROUNDS = 32;
  localparam int RULE_RUN   = 8;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    RULE_A = 1'b0,
    RULE_B = 1'b1
  } rule_t;

  typedef struct packed {
    word_t w1;
    word_t w2;
    word_t w3;
    word_t w4;
  } words_t;

  // Rule B mixes the *old* w1 into w3, not the G output.
  function automatic words_t rule_step(
    input rule_t rule,
    input word_t w1,
    input word_t w2,
    input word_t w3,
    input word_t w4,
    input word_t g,
    input word_t cnt
  );
    words_t r;
    if (rule == RULE_A) begin
      r.w1 = g ^ w4 ^ cnt;
      r.w2 = g;
      r.w3 = w2;
      r.w4 = w3;
    end else begin
      r.w1 = w4;
      r.w2 = g;
      r.w3 = w1 ^ w2 ^ cnt;
      r.w4 = w3;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/skipjack_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : skipjack_round_ctrl
//  Description : Sequences one 64-bit Skipjack encryption through 32 rounds,
//                driving an external G-permutation unit over stream handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module skipjack_round_ctrl
  import skipjack_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [79:0] key_in,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [15:0] g_m_axis_tdata,
  output logic        g_m_axis_tvalid,
  input  logic        g_m_axis_tready,
  input  logic [15:0] g_s_axis_tdata,
  input  logic        g_s_axis_tvalid,
  output logic        g_s_axis_tready,
  output logic [4:0]  g_counter,
  output logic [79:0] g_key,
  output logic        busy
);

  localparam logic [4:0] c_LAST_ROUND = 5'(NUM_ROUNDS - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  words_t      r_words;
  logic [4:0]  r_round;
  logic [79:0] r_key;
  logic        r_s_tready;

  logic        w_in_hs;
  logic        w_gres_hs;
  logic        w_last;
  rule_t       w_rule;
  word_t       w_cnt;
  words_t      w_words_nxt;

  logic        w_g_m_tvalid;
  logic        w_g_s_tready;
  logic        w_m_tvalid;
  logic        w_busy;

  assign w_in_hs     = s_axis_tvalid && r_s_tready;
  assign w_gres_hs   = (r_state == WAIT) && g_s_axis_tvalid;
  assign w_last      = (r_round == c_LAST_ROUND);
  assign w_rule      = (((int'(r_round) / RULE_RUN) % 2) == 0) ? RULE_A : RULE_B;
  assign w_cnt       = word_t'(r_round) + word_t'(1);
  assign w_words_nxt = rule_step(w_rule, r_words.w1, r_words.w2, r_words.w3,
                                 r_words.w4, g_s_axis_tdata, w_cnt);

  always_comb begin
    w_state_nxt  = r_state;
    w_g_m_tvalid = 1'b0;
    w_g_s_tready = 1'b0;
    w_m_tvalid   = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (w_in_hs) w_state_nxt = SEND;
      end
      SEND: begin
        w_g_m_tvalid = 1'b1;
        if (g_m_axis_tready) w_state_nxt = WAIT;
      end
      WAIT: begin
        w_g_s_tready = 1'b1;
        if (g_s_axis_tvalid) w_state_nxt = w_last ? DONE : SEND;
      end
      DONE: begin
        w_m_tvalid = 1'b1;
        if (m_axis_tready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Ready is registered so it reads 0 for the whole reset pulse and rises
  // on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_s_tready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_s_tready <= (w_state_nxt == IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_words <= '0;
      r_round <= '0;
      r_key   <= '0;
    end else if (w_in_hs) begin
      r_words <= words_t'(s_axis_tdata);
      r_key   <= key_in;
      r_round <= '0;
    end else if (w_gres_hs) begin
      r_words <= w_words_nxt;
      if (!w_last) r_round <= r_round + 5'd1;
    end
  end

  assign s_axis_tready   = r_s_tready;
  assign m_axis_tvalid   = w_m_tvalid;
  assign m_axis_tdata    = w_m_tvalid ? r_words : 64'd0;
  assign g_m_axis_tvalid = w_g_m_tvalid;
  assign g_m_axis_tdata  = r_words.w1;
  assign g_s_axis_tready = w_g_s_tready;
  assign g_counter       = r_round;
  assign g_key           = r_key;
  assign busy            = w_busy;

endmodule
`default_nettype wire
